// File: rtl/reg_wb_queue.sv
// Register file writeback queue: two writers in, one in-order retire per cycle.
// Optional youngest-match forwarding outputs when REG_WB_FWD_EN is defined.
module reg_wb_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_valid_i,
  input  logic [4:0]      alu_rd_i,
  input  logic [XLEN-1:0] alu_data_i,
  output logic            alu_ready_o,
  input  logic            lsu_valid_i,
  input  logic [4:0]      lsu_rd_i,
  input  logic [XLEN-1:0] lsu_data_i,
  output logic            lsu_ready_o,
  output logic            we_reg_file_o,
  output logic [4:0]      a3_reg_file_o,
  output logic [XLEN-1:0] wd_reg_file_o,
  input  logic [4:0]      rs1_i,
  input  logic [4:0]      rs2_i,
  output logic            rs1_busy_o,
  output logic            rs2_busy_o
`ifdef REG_WB_FWD_EN
  ,
  output logic [XLEN-1:0] rs1_fwd_data_o,
  output logic [XLEN-1:0] rs2_fwd_data_o
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [4:0]      rd_q   [DEPTH];
  logic [XLEN-1:0] data_q [DEPTH];
  logic [PW-1:0]   head_q, tail_q, tail2, idx;
  logic [CW-1:0]   count_q, free;
  logic            pop, enq_alu, enq_lsu;
  logic            we_q;
  logic [4:0]      a3_q;
  logic [XLEN-1:0] wd_q;

  assign pop   = (count_q != '0);
  assign free  = CW'(DEPTH) - count_q + CW'(pop);
  assign alu_ready_o = (free >= CW'(1));
  assign lsu_ready_o = alu_valid_i ? (free >= CW'(2))
                                   : (free >= CW'(1));

  // rd==0 requests are acknowledged but dropped
  assign enq_alu = alu_valid_i && alu_ready_o && (alu_rd_i != '0);
  assign enq_lsu = lsu_valid_i && lsu_ready_o && (lsu_rd_i != '0);
  assign tail2   = tail_q + PW'(enq_alu);

  always_ff @(posedge clk) begin
    if (enq_alu) begin
      rd_q[tail_q]   <= alu_rd_i;
      data_q[tail_q] <= alu_data_i;
    end
    if (enq_lsu) begin
      rd_q[tail2]   <= lsu_rd_i;
      data_q[tail2] <= lsu_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      we_q    <= 1'b0;
      a3_q    <= '0;
      wd_q    <= '0;
    end else begin
      head_q  <= head_q + PW'(pop);
      tail_q  <= tail_q + PW'(enq_alu) + PW'(enq_lsu);
      count_q <= count_q + CW'(enq_alu) + CW'(enq_lsu) - CW'(pop);
      we_q    <= pop;
      if (pop) begin
        a3_q <= rd_q[head_q];
        wd_q <= data_q[head_q];
      end
    end
  end

  assign we_reg_file_o = we_q;
  assign a3_reg_file_o = a3_q;
  assign wd_reg_file_o = wd_q;

  // Scan oldest to youngest so the last match is the youngest
  always_comb begin
    rs1_busy_o = 1'b0;
    rs2_busy_o = 1'b0;
    idx        = head_q;
`ifdef REG_WB_FWD_EN
    rs1_fwd_data_o = '0;
    rs2_fwd_data_o = '0;
`endif
    for (int j = 0; j < DEPTH; j++) begin
      idx = head_q + PW'(j);
      if (CW'(j) < count_q) begin
        if (rs1_i != '0 && rd_q[idx] == rs1_i) begin
          rs1_busy_o = 1'b1;
`ifdef REG_WB_FWD_EN
          rs1_fwd_data_o = data_q[idx];
`endif
        end
        if (rs2_i != '0 && rd_q[idx] == rs2_i) begin
          rs2_busy_o = 1'b1;
`ifdef REG_WB_FWD_EN
          rs2_fwd_data_o = data_q[idx];
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_reg_wb_queue.sv
// Randomized bench for reg_wb_queue against a queue-based reference model.
module tb_reg_wb_queue;
  localparam int DEPTH = 4;
  localparam int XLEN  = 32;

  logic clk, rst_n;
  logic alu_valid, lsu_valid, alu_ready, lsu_ready;
  logic [4:0] alu_rd, lsu_rd, a3, rs1, rs2;
  logic [31:0] alu_data, lsu_data, wd;
  logic we, busy1, busy2;
`ifdef REG_WB_FWD_EN
  logic [31:0] fwd1, fwd2;
`endif

  int tests = 0;
  int fails = 0;

  // model state: queued entries plus the registered output stage
  int          m_rd[$];
  logic [31:0] m_d[$];
  logic        e_we;
  logic [4:0]  e_a3;
  logic [31:0] e_wd;

  reg_wb_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid_i(alu_valid), .alu_rd_i(alu_rd),
    .alu_data_i(alu_data), .alu_ready_o(alu_ready),
    .lsu_valid_i(lsu_valid), .lsu_rd_i(lsu_rd),
    .lsu_data_i(lsu_data), .lsu_ready_o(lsu_ready),
    .we_reg_file_o(we), .a3_reg_file_o(a3),
    .wd_reg_file_o(wd),
    .rs1_i(rs1), .rs2_i(rs2),
    .rs1_busy_o(busy1), .rs2_busy_o(busy2)
`ifdef REG_WB_FWD_EN
    , .rs1_fwd_data_o(fwd1), .rs2_fwd_data_o(fwd2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h @%0t",
               name, act, exp, $time);
    end
  endtask

  function automatic logic m_busy(logic [4:0] rs);
    if (rs == 0) return 1'b0;
    foreach (m_rd[i]) if (m_rd[i] == int'(rs)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_fwd(logic [4:0] rs);
    logic [31:0] r = 0;
    if (rs == 0) return 0;
    foreach (m_rd[i]) if (m_rd[i] == int'(rs)) r = m_d[i];
    return r;
  endfunction

  function automatic int m_free();
    int sz = m_rd.size();
    return DEPTH - sz + ((sz > 0) ? 1 : 0);
  endfunction

  function automatic logic m_alu_rdy();
    return m_free() >= 1;
  endfunction

  function automatic logic m_lsu_rdy();
    return alu_valid ? (m_free() >= 2) : (m_free() >= 1);
  endfunction

  task automatic compare();
    chk("alu_ready", 32'(alu_ready), 32'(m_alu_rdy()));
    chk("lsu_ready", 32'(lsu_ready), 32'(m_lsu_rdy()));
    chk("we", 32'(we), 32'(e_we));
    chk("a3", 32'(a3), 32'(e_a3));
    chk("wd", wd, e_wd);
    chk("rs1_busy", 32'(busy1), 32'(m_busy(rs1)));
    chk("rs2_busy", 32'(busy2), 32'(m_busy(rs2)));
`ifdef REG_WB_FWD_EN
    chk("rs1_fwd", fwd1, m_fwd(rs1));
    chk("rs2_fwd", fwd2, m_fwd(rs2));
`endif
  endtask

  task automatic model_update();
    logic a_acc, l_acc;
    a_acc = alu_valid && m_alu_rdy();
    l_acc = lsu_valid && m_lsu_rdy();
    if (m_rd.size() > 0) begin
      e_we = 1'b1;
      e_a3 = 5'(m_rd.pop_front());
      e_wd = m_d.pop_front();
    end else begin
      e_we = 1'b0;
    end
    if (a_acc && alu_rd != 0) begin
      m_rd.push_back(int'(alu_rd));
      m_d.push_back(alu_data);
    end
    if (l_acc && lsu_rd != 0) begin
      m_rd.push_back(int'(lsu_rd));
      m_d.push_back(lsu_data);
    end
  endtask

  // one clock: check at negedge, advance model, return at posedge+1
  task automatic step();
    @(negedge clk);
    compare();
    if (rst_n) model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 0;
    lsu_valid = 0;
  endtask

  task automatic do_reset();
    alu_valid = 1;
    lsu_valid = 1;
    rs1 = 5'd3;
    rs2 = 5'd4;
    rst_n = 0;
    #1;
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_a3", 32'(a3), 32'd0);
    chk("rst_wd", wd, 32'd0);
    chk("rst_busy1", 32'(busy1), 32'd0);
    chk("rst_busy2", 32'(busy2), 32'd0);
    chk("rst_alu_rdy", 32'(alu_ready), 32'd1);
    chk("rst_lsu_rdy", 32'(lsu_ready), 32'd1);
    m_rd.delete();
    m_d.delete();
    e_we = 0;
    e_a3 = 0;
    e_wd = 0;
    step();
    rst_n = 1;
    idle();
  endtask

  initial begin
    rst_n = 1;
    idle();
    alu_rd = 0; lsu_rd = 0;
    alu_data = 0; lsu_data = 0;
    rs1 = 0; rs2 = 0;
    e_we = 0; e_a3 = 0; e_wd = 0;
    @(posedge clk);
    #1;
    do_reset();
    step();

    // single ALU writeback, rd=5
    alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF; rs1 = 5;
    step();
    idle();
    chk("t2_busy_k", 32'(busy1), 32'd1);
    chk("t2_we_k", 32'(we), 32'd0);
`ifdef REG_WB_FWD_EN
    chk("t2_fwd", fwd1, 32'hDEADBEEF);
`endif
    step();
    chk("t2_we", 32'(we), 32'd1);
    chk("t2_a3", 32'(a3), 32'd5);
    chk("t2_wd", wd, 32'hDEADBEEF);
    chk("t2_busy_k1", 32'(busy1), 32'd0);
    step();
    chk("t2_we_off", 32'(we), 32'd0);

    // ALU and LSU together: ALU retires first
    alu_valid = 1; alu_rd = 1; alu_data = 32'h11;
    lsu_valid = 1; lsu_rd = 2; lsu_data = 32'h22;
    step();
    idle();
    step();
    chk("t3_a3_first", 32'(a3), 32'd1);
    chk("t3_wd_first", wd, 32'h11);
    step();
    chk("t3_a3_second", 32'(a3), 32'd2);
    chk("t3_wd_second", wd, 32'h22);
    step();

    // rd=0 is consumed but never written
    alu_valid = 1; alu_rd = 0; alu_data = 32'hFFFFFFFF; rs1 = 0;
    #1;
    chk("t5_alu_rdy", 32'(alu_ready), 32'd1);
    step();
    idle();
    chk("t5_we_k", 32'(we), 32'd0);
    chk("t5_busy", 32'(busy1), 32'd0);
    step();
    chk("t5_we_k1", 32'(we), 32'd0);

    // two writes to x7 in one cycle: youngest forwarded, both retire
    alu_valid = 1; alu_rd = 7; alu_data = 32'hA;
    lsu_valid = 1; lsu_rd = 7; lsu_data = 32'hB;
    rs1 = 7;
    step();
    idle();
    chk("t6_busy", 32'(busy1), 32'd1);
`ifdef REG_WB_FWD_EN
    chk("t6_fwd", fwd1, 32'hB);
`endif
    step();
    chk("t6_wd_a", wd, 32'hA);
    chk("t6_busy_mid", 32'(busy1), 32'd1);
    step();
    chk("t6_wd_b", wd, 32'hB);
    chk("t6_busy_end", 32'(busy1), 32'd0);
    step();

    // saturate with both writers every cycle
    for (int i = 0; i < 6; i++) begin
      alu_valid = 1; alu_rd = 5'(8 + 2 * i); alu_data = $urandom;
      lsu_valid = 1; lsu_rd = 5'(9 + 2 * i); lsu_data = $urandom;
      step();
    end
    #1;
    chk("t4_lsu_rdy_full", 32'(lsu_ready), 32'd0);
    chk("t4_alu_rdy_full", 32'(alu_ready), 32'd1);
    idle();
    for (int i = 0; i < DEPTH + 2; i++) step();

    // random traffic with a mid-run reset
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset();
      alu_valid = ($urandom_range(0, 3) != 0);
      lsu_valid = ($urandom_range(0, 2) != 0);
      alu_rd = 5'($urandom_range(0, 7));
      lsu_rd = 5'($urandom_range(0, 7));
      alu_data = $urandom;
      lsu_data = $urandom;
      rs1 = 5'($urandom_range(0, 7));
      rs2 = 5'($urandom_range(0, 7));
      step();
    end
    idle();
    for (int i = 0; i < DEPTH + 2; i++) step();
    chk("drained_we", 32'(we), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
